// File: rtl/ah_demux_route_stage_if.sv
// Bus bundle between the route stage, its upstream source and the downstream AH demux.
// Handshake: a beat moves on a rising edge where valid && ready; the sender keeps data stable while valid && !ready.
interface ah_demux_route_stage_if #(
  parameter int DATA_W = 34,
  parameter int SEL_W  = 3
);
  logic [DATA_W-1:0] ing_data;
  logic              ing_valid;
  logic              ing_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_select;

  modport master (
    input  ing_data, ing_valid, out_ready,
    output ing_ready, out_data, out_valid, out_select
  );

  modport slave (
    output ing_data, ing_valid, out_ready,
    input  ing_ready, out_data, out_valid, out_select
  );
endinterface

// File: rtl/ah_demux_route_stage.sv
// Registered ingress stage ahead of the AH 1:N demux: tags every beat with its packet's destination.
// Optional ROUTE_DROP_EN: drop packets with an out-of-range destination instead of clamping them.
module ah_demux_route_stage #(
  parameter int DATA_W   = 34,
  parameter int NUM_EGR  = 7,
  parameter int SEL_W    = 3,
  parameter int DEST_LSB = 0
) (
  input  logic        clk,
  input  logic        rst,
  ah_demux_route_stage_if.master bus,
  output logic        pkt_active,
  output logic [1:0]  fsm_state
`ifdef ROUTE_DROP_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

`ifdef ROUTE_DROP_EN
  typedef enum logic [1:0] {ST_HDR = 2'd0, ST_BODY = 2'd1, ST_DROP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_HDR = 2'd0, ST_BODY = 2'd1} state_t;
`endif

  localparam logic [SEL_W:0]   EGR_LIMIT = (SEL_W+1)'(NUM_EGR);
  localparam logic [SEL_W-1:0] MAX_SEL   = SEL_W'(NUM_EGR - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0]  main_sel_q, main_sel_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0]  skid_sel_q, skid_sel_d;
  logic              ing_ready_q;

  logic [SEL_W-1:0]  hdr_dest;
  logic              dest_ok;
  logic              eop;
  logic              accept;
  logic              retire;
  logic              beat_keep;
  logic [SEL_W-1:0]  beat_sel;
`ifdef ROUTE_DROP_EN
  logic              hdr_drop;
`endif

  assign hdr_dest = bus.ing_data[DEST_LSB +: SEL_W];
  assign dest_ok  = {1'b0, hdr_dest} < EGR_LIMIT;
  assign eop      = bus.ing_data[DATA_W-1];
  assign accept   = bus.ing_valid & ing_ready_q;
  assign retire   = main_valid_q & bus.out_ready;

  // Ingress packet FSM: decides each accepted beat's select and whether it is kept.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    beat_sel  = cur_sel_q;
    beat_keep = 1'b0;
`ifdef ROUTE_DROP_EN
    hdr_drop  = 1'b0;
`endif
    case (state_q)
      ST_HDR: begin
        if (accept) begin
`ifdef ROUTE_DROP_EN
          if (!dest_ok) begin
            hdr_drop = 1'b1;
            state_d  = eop ? ST_HDR : ST_DROP;
          end else begin
            beat_sel  = hdr_dest;
            cur_sel_d = hdr_dest;
            beat_keep = 1'b1;
            state_d   = eop ? ST_HDR : ST_BODY;
          end
`else
          beat_sel  = dest_ok ? hdr_dest : MAX_SEL;
          cur_sel_d = beat_sel;
          beat_keep = 1'b1;
          state_d   = eop ? ST_HDR : ST_BODY;
`endif
        end
      end
      ST_BODY: begin
        if (accept) begin
          beat_keep = 1'b1;
          if (eop) state_d = ST_HDR;
        end
      end
`ifdef ROUTE_DROP_EN
      ST_DROP: begin
        if (accept && eop) state_d = ST_HDR;
      end
`endif
      default: state_d = ST_HDR;
    endcase
  end

  // Two-entry skid: skid only fills when main is held; it always drains into main first.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_sel_d   = main_sel_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    if (retire) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_sel_d   = skid_sel_q;
        skid_valid_d = 1'b0;
      end else if (beat_keep) begin
        main_data_d  = bus.ing_data;
        main_sel_d   = beat_sel;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (beat_keep) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = bus.ing_data;
        main_sel_d   = beat_sel;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = bus.ing_data;
        skid_sel_d   = beat_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HDR;
      cur_sel_q    <= '0;
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_sel_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      ing_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_sel_q    <= cur_sel_d;
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_sel_q   <= main_sel_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      ing_ready_q  <= !skid_valid_d;
    end
  end

`ifdef ROUTE_DROP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= 16'h0000;
    end else if (hdr_drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'h0001;
    end
  end
`endif

  assign bus.ing_ready  = ing_ready_q;
  assign bus.out_valid  = main_valid_q;
  assign bus.out_data   = main_data_q;
  assign bus.out_select = main_sel_q;
  assign pkt_active     = (state_q == ST_BODY);
  assign fsm_state      = state_q;

endmodule
